// File: rtl/cachepkg.sv
// Shared state encoding, geometry helpers and line layout for the l1_cache family.
package cachepkg;

  typedef enum logic [1:0] {
    IDLE,
    RESPOND,
    WRITEBACK,
    FILL
  } cache_state_t;

  localparam int WAYS         = 4;
  localparam int DEFAULT_SETS = 16;

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int addr_width, input int sets);
    return addr_width - 2 - $clog2(sets);
  endfunction

  localparam int DEFAULT_TAG_W = tag_width(32, DEFAULT_SETS);

  // Line layout at the default geometry; the cache re-derives it for its own parameters.
  typedef struct packed {
    logic                     valid;
    logic                     dirty;
    logic [DEFAULT_TAG_W-1:0] tag;
    logic [31:0]              data;
  } line_t;

endpackage

// File: rtl/plru4.sv
// Three-bit tree pseudo-LRU for one 4-way set: picks the victim and computes
// the tree after an access so that it points away from the accessed way.
module plru4 (
  input  logic [2:0] tree,
  input  logic [1:0] way,
  output logic [2:0] next_tree,
  output logic [1:0] victim
);

  // bit 0 chooses the pair, bit 1 resolves ways 0/1, bit 2 resolves ways 2/3
  always_comb begin
    next_tree = tree;
    if (!way[1]) begin
      next_tree[0] = 1'b1;
      next_tree[1] = ~way[0];
    end else begin
      next_tree[0] = 1'b0;
      next_tree[2] = ~way[0];
    end
  end

  assign victim = tree[0] ? {1'b1, tree[2]} : {1'b0, tree[1]};

endmodule

// File: rtl/l1_cache.sv
// Four-way set-associative, write-back, write-allocate cache with one word per line.
// Define CACHE_STATS_EN to add saturating hit/miss/evict counters as outputs.
module l1_cache
  import cachepkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32,
  parameter int SETS         = DEFAULT_SETS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDRESSWIDTH-1:0] cpu_addr,
  input  logic [DATAWIDTH-1:0]    cpu_wdata,
  output logic [DATAWIDTH-1:0]    cpu_rdata,
  output logic                    cpu_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_wdata,
  input  logic [DATAWIDTH-1:0]    mem_rdata,
  input  logic                    mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             evict_count
`endif
);

  localparam int IDXW = index_width(SETS);
  localparam int TAGW = tag_width(ADDRESSWIDTH, SETS);
  localparam int WAYW = $clog2(WAYS);

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAGW-1:0]      tag;
    logic [DATAWIDTH-1:0] data;
  } cache_line_t;

  cache_line_t          lines [SETS][WAYS];
  logic [2:0]           plru  [SETS];
  cache_state_t         state;
  logic                 req_we;
  logic [TAGW-1:0]      req_tag;
  logic [IDXW-1:0]      req_index;
  logic [DATAWIDTH-1:0] req_wdata;
  logic [WAYW-1:0]      victim_q;

  logic [TAGW-1:0] cpu_tag;
  logic [IDXW-1:0] cpu_index;
  logic            unused_offset;

  assign cpu_tag       = cpu_addr[ADDRESSWIDTH-1 -: TAGW];
  assign cpu_index     = cpu_addr[2 +: IDXW];
  assign unused_offset = ^cpu_addr[1:0];

  logic            hit;
  logic            inv_found;
  logic [WAYW-1:0] hit_way;
  logic [WAYW-1:0] inv_way;
  logic [WAYW-1:0] victim_sel;
  logic [WAYW-1:0] plru_victim;
  logic [WAYW-1:0] plru_way;
  logic [2:0]      plru_tree;
  logic [2:0]      plru_next;
  cache_line_t     victim_line;

  // Walk ways from the top down so the lowest-index invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!lines[cpu_index][w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end else if (lines[cpu_index][w].tag == cpu_tag) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
    end
  end

  assign victim_sel  = inv_found ? inv_way : plru_victim;
  assign victim_line = lines[cpu_index][victim_sel];
  assign plru_tree   = (state == IDLE) ? plru[cpu_index] : plru[req_index];
  assign plru_way    = (state != IDLE) ? victim_q : (hit ? hit_way : victim_sel);

  plru4 u_plru (
    .tree      (plru_tree),
    .way       (plru_way),
    .next_tree (plru_next),
    .victim    (plru_victim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          lines[s][w] <= '0;
        end
      end
      state     <= IDLE;
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_index <= '0;
      req_wdata <= '0;
      victim_q  <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_tag;
            req_index <= cpu_index;
            req_wdata <= cpu_wdata;
            victim_q  <= victim_sel;
            if (hit) begin
              plru[cpu_index] <= plru_next;
              if (cpu_we) begin
                lines[cpu_index][hit_way].data  <= cpu_wdata;
                lines[cpu_index][hit_way].dirty <= 1'b1;
                cpu_rdata <= cpu_wdata;
              end else begin
                cpu_rdata <= lines[cpu_index][hit_way].data;
              end
              cpu_ready <= 1'b1;
              state     <= RESPOND;
            end else if (victim_line.valid && victim_line.dirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {victim_line.tag, cpu_index, 2'b00};
              mem_wdata <= victim_line.data;
              state     <= WRITEBACK;
            end else if (!cpu_we) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {cpu_tag, cpu_index, 2'b00};
              state    <= FILL;
            end else begin
              // A one-word line is fully overwritten, so a clean write miss needs no fill.
              lines[cpu_index][victim_sel] <= '{valid: 1'b1, dirty: 1'b1, tag: cpu_tag, data: cpu_wdata};
              plru[cpu_index] <= plru_next;
              cpu_rdata       <= cpu_wdata;
              cpu_ready       <= 1'b1;
              state           <= RESPOND;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (req_we) begin
              lines[req_index][victim_q] <= '{valid: 1'b1, dirty: 1'b1, tag: req_tag, data: req_wdata};
              plru[req_index] <= plru_next;
              cpu_rdata       <= req_wdata;
              cpu_ready       <= 1'b1;
              state           <= RESPOND;
            end else begin
              lines[req_index][victim_q].dirty <= 1'b0;
              mem_addr <= {req_tag, req_index, 2'b00};
              state    <= FILL;
            end
          end
        end
        FILL: begin
          // After a writeback mem_req is low for one cycle before the fill request rises.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            lines[req_index][victim_q] <= '{valid: 1'b1, dirty: 1'b0, tag: req_tag, data: mem_rdata};
            plru[req_index] <= plru_next;
            cpu_rdata       <= mem_rdata;
            cpu_ready       <= 1'b1;
            state           <= RESPOND;
          end
        end
        RESPOND: begin
          cpu_ready <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count   <= '0;
      miss_count  <= '0;
      evict_count <= '0;
    end else if (state == IDLE && cpu_req) begin
      if (hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
        if (victim_line.valid && victim_line.dirty && evict_count != '1) begin
          evict_count <= evict_count + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: CPU requests with scoreboarded expectations against
// a two-cycle-latency memory model that logs every downstream transaction.
module tb_l1_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, evict_count;
`endif

  always #5 clock = ~clock;

  l1_cache dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .evict_count (evict_count)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  mem_txn_t    mem_log[$];
  logic [31:0] backing[logic [31:0]];
  logic [31:0] scoreboard[$];
  int          total = 0;
  int          bad = 0;
  int          mem_req_cycles = 0;

  function automatic logic [31:0] fill_pattern(input logic [31:0] addr);
    if (addr == 32'h40) return 32'hDEADBEEF;
    return addr ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mem_value(input logic [31:0] addr);
    if (backing.exists(addr)) return backing[addr];
    return fill_pattern(addr);
  endfunction

  function automatic mem_txn_t txnAt(input int i);
    mem_txn_t t;
    t.we = 1'bx;
    t.addr = 'x;
    t.data = 'x;
    if (i >= 0 && i < mem_log.size()) t = mem_log[i];
    return t;
  endfunction

  always @(posedge clock) if (mem_req === 1'b1) mem_req_cycles++;

  // Memory model answers two negedges after it sees mem_req, for one cycle.
  initial begin
    int wait_cnt;
    mem_txn_t txn;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_req === 1'b1) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          wait_cnt = 0;
          txn.we   = mem_we;
          txn.addr = mem_addr;
          txn.data = mem_we ? mem_wdata : mem_value(mem_addr);
          mem_log.push_back(txn);
          if (mem_we) backing[mem_addr] = mem_wdata;
          else mem_rdata = txn.data;
          mem_ready = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expected, input string tag, output int latency);
    int n;
    scoreboard.push_back(expected);
    @(negedge clock);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (cpu_ready !== 1'b1 && n < 100);
    latency = n;
    checkOutput({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    checkOutput({tag, "_rdata"}, cpu_rdata, scoreboard.pop_front());
    cpu_req = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    cpu_req = 1'b0;
    reset   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic readHit(input logic [31:0] addr, input logic [31:0] expected, input string tag);
    int lat;
    int req0;
    req0 = mem_req_cycles;
    applyStimulus(1'b0, addr, 32'h0, expected, tag, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd1);
    checkOutput({tag, "_no_mem_req"}, 32'(mem_req_cycles - req0), 32'd0);
  endtask

  task automatic readMiss(input logic [31:0] addr, input logic [31:0] expected, input string tag);
    int lat;
    applyStimulus(1'b0, addr, 32'h0, expected, tag, lat);
    checkOutput({tag, "_went_to_mem"}, 32'(lat > 1), 32'd1);
  endtask

  initial begin
    int lat;
    int n0;
    int req0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    reset     = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    // Clean read miss, then the same address hits.
    n0 = mem_log.size();
    readMiss(32'h40, 32'hDEADBEEF, "rd40_miss");
    checkOutput("rd40_fill_count", 32'(mem_log.size() - n0), 32'd1);
    checkOutput("rd40_fill_we", 32'(txnAt(n0).we), 32'd0);
    checkOutput("rd40_fill_addr", txnAt(n0).addr, 32'h40);
    readHit(32'h40, 32'hDEADBEEF, "rd40_hit");

    // Clean write miss installs without touching memory.
    req0 = mem_req_cycles;
    applyStimulus(1'b1, 32'h80, 32'h12345678, 32'h12345678, "wr80", lat);
    checkOutput("wr80_latency", 32'(lat), 32'd1);
    checkOutput("wr80_no_mem_req", 32'(mem_req_cycles - req0), 32'd0);
    readHit(32'h80, 32'h12345678, "rd80_hit");

    // PLRU victim: after touching way 0 the tree points at the 2/3 pair, way 2 goes.
    doReset();
    readMiss(32'h000, fill_pattern(32'h000), "plru_fill0");
    readMiss(32'h400, fill_pattern(32'h400), "plru_fill1");
    readMiss(32'h800, fill_pattern(32'h800), "plru_fill2");
    readMiss(32'hC00, fill_pattern(32'hC00), "plru_fill3");
    readHit(32'h000, fill_pattern(32'h000), "plru_touch0");
    n0 = mem_log.size();
    readMiss(32'h1000, fill_pattern(32'h1000), "plru_rd1000");
    checkOutput("plru_rd1000_count", 32'(mem_log.size() - n0), 32'd1);
    checkOutput("plru_rd1000_addr", txnAt(n0).addr, 32'h1000);
    readHit(32'h000, fill_pattern(32'h000), "plru_keep0");
    readHit(32'hC00, fill_pattern(32'hC00), "plru_keep3");
    readHit(32'h400, fill_pattern(32'h400), "plru_keep1");
    readMiss(32'h800, fill_pattern(32'h800), "plru_evicted2");

    // Dirty victim: writeback of way 0 precedes the fill of the new line.
    doReset();
    req0 = mem_req_cycles;
    applyStimulus(1'b1, 32'h000, 32'hA5A5A5A5, 32'hA5A5A5A5, "dirty_wr0", lat);
    checkOutput("dirty_wr0_no_mem_req", 32'(mem_req_cycles - req0), 32'd0);
    readMiss(32'h400, fill_pattern(32'h400), "dirty_fill1");
    readMiss(32'h800, fill_pattern(32'h800), "dirty_fill2");
    readMiss(32'hC00, fill_pattern(32'hC00), "dirty_fill3");
    n0 = mem_log.size();
    readMiss(32'h1000, fill_pattern(32'h1000), "dirty_rd1000");
    checkOutput("dirty_txn_count", 32'(mem_log.size() - n0), 32'd2);
    checkOutput("dirty_wb_we", 32'(txnAt(n0).we), 32'd1);
    checkOutput("dirty_wb_addr", txnAt(n0).addr, 32'h000);
    checkOutput("dirty_wb_data", txnAt(n0).data, 32'hA5A5A5A5);
    checkOutput("dirty_fill_we", 32'(txnAt(n0 + 1).we), 32'd0);
    checkOutput("dirty_fill_addr", txnAt(n0 + 1).addr, 32'h1000);
    readMiss(32'h000, 32'hA5A5A5A5, "dirty_reread0");

    // Reset while the fill request is outstanding.
    doReset();
    @(negedge clock);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h2000;
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clock);
    checkOutput("rstmid_req_seen", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rstmid_req_drop", 32'(mem_req), 32'd0);
    checkOutput("rstmid_ready_low", 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n0 = mem_log.size();
    readMiss(32'h2000, fill_pattern(32'h2000), "rstmid_reread");
    checkOutput("rstmid_reread_count", 32'(mem_log.size() - n0), 32'd1);
    checkOutput("rstmid_reread_addr", txnAt(n0).addr, 32'h2000);

`ifdef CACHE_STATS_EN
    doReset();
    checkOutput("stats_reset_hits", hit_count, 32'd0);
    readMiss(32'h40, 32'hDEADBEEF, "stats_m0");
    readMiss(32'h80, fill_pattern(32'h80), "stats_m1");
    readHit(32'h40, 32'hDEADBEEF, "stats_h0");
    readMiss(32'h400, fill_pattern(32'h400), "stats_m2");
    readHit(32'h80, fill_pattern(32'h80), "stats_h1");
    checkOutput("stats_miss_count", miss_count, 32'd3);
    checkOutput("stats_hit_count", hit_count, 32'd2);
    checkOutput("stats_evict_count", evict_count, 32'd0);
`endif

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_cache.md
# l1_cache

Parameterised single-level, 4-way set-associative, write-back, write-allocate cache with one 32-bit word per line. The design instantiates it twice, as a data cache and as an instruction cache. Each instance sits between a requester (CPU or trace driver) on its upstream port and the next memory level on its downstream port. Both ports are request/ready handshakes carried on the codebase's cache interface bundle.

## Interface
- DATAWIDTH, 32, word width on both ports
- ADDRESSWIDTH, 32, byte-address width on both ports
- SETS, 16, number of sets; must be a power of two
- clock  in  1  single clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cpu_req  in  1  upstream request strobe
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDRESSWIDTH  byte address; bits [1:0] are ignored
- cpu_wdata  in  DATAWIDTH  write data
- cpu_rdata  out  DATAWIDTH  read data, valid while cpu_ready = 1
- cpu_ready  out  1  one-cycle completion pulse
- mem_req  out  1  downstream request; held until mem_ready
- mem_we  out  1  1 = writeback, 0 = fill
- mem_addr  out  ADDRESSWIDTH  word-aligned downstream address
- mem_wdata  out  DATAWIDTH  writeback data
- mem_rdata  in  DATAWIDTH  fill data, valid with mem_ready
- mem_ready  in  1  downstream completion

## Operation
- Address split: offset = [1:0], index = next log2(SETS) bits, tag = the remaining upper bits.
- Per way: valid, dirty, tag, data. Per set: 3-bit pseudo-LRU (PLRU) tree.
- FSM states: IDLE, RESPOND, WRITEBACK, FILL.
- IDLE:
  - Sample cpu_req and latch the address, write data and direction.
  - Hit when some way is valid and its tag matches. Go to RESPOND.
    - Read hit: return that way's data.
    - Write hit: store cpu_wdata and set dirty.
  - On a miss, choose a victim: the lowest-index invalid way; otherwise the PLRU victim.
    - Dirty victim: go to WRITEBACK.
    - Clean victim, read miss: go to FILL.
    - Clean victim, write miss: install the line directly and go to RESPOND. There is no fill, because lines are one full word.
- WRITEBACK:
  - Drive mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim data.
  - On mem_ready: clear dirty, then go to FILL (read miss) or install the line and go to RESPOND (write miss).
- FILL:
  - Drive mem_req = 1, mem_we = 0, mem_addr = {tag, index, 2'b00}.
  - On mem_ready: install the line as valid and clean with mem_rdata, then go to RESPOND.
- RESPOND:
  - Assert cpu_ready for exactly one cycle. cpu_rdata carries the read data; on writes it echoes the written data.
  - Return to IDLE. cpu_req is ignored while in this state.
- A write-miss install sets valid = 1, dirty = 1 and data = cpu_wdata.
- PLRU encoding: b0 = 0 selects the ways 0/1 pair, b0 = 1 selects the ways 2/3 pair. b1 picks within ways 0/1 (0 → way 0); b2 picks within ways 2/3 (0 → way 2).
- Every hit or install updates the tree to point away from the accessed way.
- mem_ready is ignored when mem_req = 0.

## Timing
- Reset: every valid, dirty and PLRU bit is 0, the FSM is in IDLE, and all outputs are 0.
- Hit: request sampled at edge T, cpu_ready high during cycle T+1. The maximum rate is one access every 2 cycles.
- Clean miss: cpu_ready is high 1 cycle after the mem_ready edge of the fill.
- Dirty read miss: writeback handshake, then fill handshake, then RESPOND.
- mem_req and mem_addr are registered. They stay stable from assertion until the mem_ready edge, and mem_req deasserts the cycle after it.
- The requester must hold its inputs until cpu_ready. It may present the next request in the cycle after cpu_ready.
- Reset mid-miss: mem_req drops immediately (asynchronous). A partially installed line is never left valid.

## Configuration
- CACHE_STATS_EN defined: add outputs hit_count, miss_count and evict_count, each 32 bits.
  - Each increments once per IDLE lookup classification.
  - evict_count counts dirty writebacks only.
  - All three saturate at all-ones and clear on reset.
- CACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package cachepkg holds:
  - the FSM state enum
  - WAYS = 4
  - the default SETS
  - the line struct {valid, dirty, tag, data}
  - tag/index width functions derived from ADDRESSWIDTH and SETS
- One sub-module, plru4:
  - input: the current 3 bits and the accessed way
  - outputs: the next 3 bits and the victim way
  - purely combinational

## Test plan
- Reset, then read 0x0000_0040 with mem_rdata = 0xDEADBEEF → fill on mem_addr 0x40; cpu_rdata = 0xDEADBEEF. A repeat read is a hit: cpu_ready at T+1, no mem_req.
- Write 0x0000_0080 ← 0x12345678 (miss) → no mem_req. A subsequent read returns 0x12345678 as a hit.
- Fill 4 distinct tags into set 0 (0x000, 0x400, 0x800, 0xC00), then touch way 0 and read 0x1000 → the victim is way 2 by PLRU (way 0 was touched last, so the tree points to the ways 2/3 pair).
- Dirty victim: write 0x000 ← 0xA5A5A5A5, fill the set, force eviction of way 0 → a writeback of 0xA5A5A5A5 to 0x000 precedes the fill.
- Assert reset while mem_req is high in FILL → mem_req = 0 at once; a re-read of the same address misses.
- With CACHE_STATS_EN: 3 misses and 2 hits → miss_count = 3, hit_count = 2, evict_count = 0.
